bus_host_arbiter: RTL and testbench

- Shares the single SoC host bus (the bus feeding the device hub) between NHOSTS bus masters, e.g. CPU core0 plus a DMA engine or debug loader.
- Round-robin, one transaction in flight, whole-transaction lock.
- Sits between the masters and the hub's host_* port.
- Request fields are latched at grant, so downstream sees stable signals until ready.

---
 rtl/bus_arb_pkg.sv | 29 ++
 rtl/rr_pick.sv | 47 ++++
 rtl/bus_host_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_bus_host_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_arb_pkg                                                          |
// | Shared types and constants for the host-bus arbiter and its          |
// | round-robin selector.                                                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package bus_arb_pkg;

   // Arbiter sequencing: pick a host, run its transaction, then one idle gap
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   // Read data returned to a host whose transaction the watchdog had to end
   localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

   // Width of every host index (grant_idx, last grant); covers up to 8 hosts
   localparam int ARB_IDX_W = 3;

   // Low bit of slice idx inside a packed per-host vector of width-bit fields
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick                                                              |
// | Combinational round-robin priority selector: the first requester     |
// | found scanning upward from (last+1) mod N, wrapping, wins.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 3
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   int w_best_dist;
   int w_dist;

   // Requester with the smallest rotational distance past i_last wins
   always_comb begin
      o_any       = 1'b0;
      o_idx       = '0;
      w_best_dist = N;
      w_dist      = 0;
      for (int c = 0; c < N; c++) begin
         w_dist = (c - int'(i_last) - 1 + 2 * N) % N;
         if (i_req[c] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            o_idx       = IW'(c);
            o_any       = 1'b1;
         end
      end
   end

   // One-hot form of the chosen index
   always_comb begin
      o_grant = '0;
      for (int c = 0; c < N; c++) begin
         o_grant[c] = o_any && (o_idx == IW'(c));
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_host_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_host_arbiter                                                     |
// | Round-robin arbiter sharing one host bus between NHOSTS masters.     |
// | One transaction in flight; request fields are latched at grant and   |
// | every completion is followed by a one-cycle gap.                     |
// | Optional macro ARB_TIMEOUT_EN adds a watchdog that ends a stalled    |
// | transfer after TIMEOUT cycles with sticky timeout_err.               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module bus_host_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NHOSTS  = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NHOSTS*32-1:0]  host_addr,
   input  logic [NHOSTS*32-1:0]  host_wdata,
   input  logic [NHOSTS*4-1:0]   host_wmask,
   input  logic [NHOSTS-1:0]     host_wen,
   input  logic [NHOSTS-1:0]     host_ren,
   output logic [31:0]           host_rdata,
   output logic [NHOSTS-1:0]     host_ready,
   output logic [31:0]           bus_addr,
   output logic [31:0]           bus_wdata,
   output logic [3:0]            bus_wmask,
   output logic                  bus_wen,
   output logic                  bus_ren,
   input  logic [31:0]           bus_rdata,
   input  logic                  bus_ready,
   output logic [2:0]            grant_idx,
   output logic                  busy,
   output logic                  timeout_err
);

   arb_state_t             r_state;
   logic [ARB_IDX_W-1:0]   r_last;
   logic [ARB_IDX_W-1:0]   r_grant;
   logic [31:0]            r_addr;
   logic [31:0]            r_wdata;
   logic [3:0]             r_wmask;
   logic                   r_wen;
   logic                   r_ren;
   logic                   r_busy;

   logic [NHOSTS-1:0]      w_req;
   logic [NHOSTS-1:0]      w_pick_onehot;
   logic [ARB_IDX_W-1:0]   w_pick_idx;
   logic                   w_pick_any;
   logic [31:0]            w_sel_addr;
   logic [31:0]            w_sel_wdata;
   logic [3:0]             w_sel_wmask;
   logic                   w_sel_wen;
   logic                   w_sel_ren;
   logic                   w_timeout;
   logic                   w_done;

   assign w_req = host_wen | host_ren;

   rr_pick #(
      .N  (NHOSTS),
      .IW (ARB_IDX_W)
   ) u_rr_pick (
      .i_req   (w_req),
      .i_last  (r_last),
      .o_grant (w_pick_onehot),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   // Route the chosen host's request fields toward the latch
   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_wmask = '0;
      w_sel_wen   = 1'b0;
      w_sel_ren   = 1'b0;
      for (int c = 0; c < NHOSTS; c++) begin
         if (w_pick_onehot[c]) begin
            w_sel_addr  = host_addr[slice_lo(c, 32) +: 32];
            w_sel_wdata = host_wdata[slice_lo(c, 32) +: 32];
            w_sel_wmask = host_wmask[slice_lo(c, 4) +: 4];
            w_sel_wen   = host_wen[c];
            w_sel_ren   = host_ren[c];
         end
      end
   end

   // A transfer ends on device ready, or on the watchdog when it is built in
   assign w_done = (r_state == XFER) && (bus_ready || w_timeout);

`ifdef ARB_TIMEOUT_EN
   localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TCW-1:0] r_tcnt;
   logic           r_terr;

   // Count cycles spent in XFER; held at zero elsewhere so each transfer starts from 0
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tcnt <= '0;
         r_terr <= 1'b0;
      end else begin
         if ((r_state == XFER) && !w_done) begin
            r_tcnt <= r_tcnt + 1'b1;
         end else begin
            r_tcnt <= '0;
         end
         if (w_timeout) begin
            r_terr <= 1'b1;
         end
      end
   end

   // A device ready in the expiry cycle takes priority over the watchdog
   assign w_timeout   = (r_state == XFER) && !bus_ready && (r_tcnt == TCW'(TIMEOUT - 1));
   assign timeout_err = r_terr;
`else
   logic w_unused_timeout;

   assign w_timeout        = 1'b0;
   assign timeout_err      = 1'b0;
   assign w_unused_timeout = (TIMEOUT != 0);
`endif

   // Arbitrate in IDLE, hold the latched request in XFER, insert one GAP cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_last  <= ARB_IDX_W'(NHOSTS - 1);
         r_grant <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_wen   <= 1'b0;
         r_ren   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_any) begin
                  r_grant <= w_pick_idx;
                  r_addr  <= w_sel_addr;
                  r_wdata <= w_sel_wdata;
                  r_wmask <= w_sel_wmask;
                  r_wen   <= w_sel_wen;
                  r_ren   <= w_sel_ren;
                  r_busy  <= 1'b1;
                  r_state <= XFER;
               end
            end
            XFER: begin
               if (w_done) begin
                  r_last  <= r_grant;
                  r_wen   <= 1'b0;
                  r_ren   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= GAP;
               end
            end
            GAP: begin
               r_state <= IDLE;
            end
            default: begin
               r_wen   <= 1'b0;
               r_ren   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Completion pulse goes only to the granted host
   always_comb begin
      host_ready = '0;
      for (int c = 0; c < NHOSTS; c++) begin
         host_ready[c] = w_done && (r_grant == ARB_IDX_W'(c));
      end
   end

   assign host_rdata = w_timeout ? ARB_TIMEOUT_DATA : bus_rdata;
   assign bus_addr   = r_addr;
   assign bus_wdata  = r_wdata;
   assign bus_wmask  = r_wmask;
   assign bus_wen    = r_wen;
   assign bus_ren    = r_ren;
   assign grant_idx  = r_grant;
   assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bus_host_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_host_arbiter                                                  |
// | Scoreboard bench: stimulus pushes expected transactions in the       |
// | round-robin order, a monitor pops them as the DUT presents them.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_bus_host_arbiter;

   localparam int NH  = 3;
   localparam int TMO = 16;

   typedef struct {
      int          host;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic        wen;
      logic        ren;
      bit          tmo;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NH*32-1:0]  host_addr  = '0;
   logic [NH*32-1:0]  host_wdata = '0;
   logic [NH*4-1:0]   host_wmask = '0;
   logic [NH-1:0]     host_wen   = '0;
   logic [NH-1:0]     host_ren   = '0;
   logic [31:0]       host_rdata;
   logic [NH-1:0]     host_ready;
   logic [31:0]       bus_addr;
   logic [31:0]       bus_wdata;
   logic [3:0]        bus_wmask;
   logic              bus_wen;
   logic              bus_ren;
   logic [31:0]       bus_rdata = '0;
   logic              bus_ready = 1'b0;
   logic [2:0]        grant_idx;
   logic              busy;
   logic              timeout_err;

   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        exp_q[$];
   logic [31:0] rdq[$];
   bit          m_terr = 1'b0;
   int          m_last = NH - 1;

   bit          dev_en = 1'b1;
   int          dev_lat = -1;
   bit          dev_fix = 1'b0;
   logic [31:0] dev_data_fix = '0;

   bit          fx_en = 1'b0;
   logic [31:0] fx_addr = '0;
   logic [31:0] fx_wdata = '0;
   logic [31:0] fx_mut = '0;
   logic [3:0]  fx_wmask = '0;
   logic [1:0]  fx_kind = 2'b01;

   bus_host_arbiter #(
      .NHOSTS  (NH),
      .TIMEOUT (TMO)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_wmask  (host_wmask),
      .host_wen    (host_wen),
      .host_ren    (host_ren),
      .host_rdata  (host_rdata),
      .host_ready  (host_ready),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_wmask   (bus_wmask),
      .bus_wen     (bus_wen),
      .bus_ren     (bus_ren),
      .bus_rdata   (bus_rdata),
      .bus_ready   (bus_ready),
      .grant_idx   (grant_idx),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Device model: ready after a chosen latency; random idle data and stray ready pulses
   initial begin
      int dev_wait;
      dev_wait = 0;
      forever begin
         @(posedge clk);
         #1;
         bus_ready = 1'b0;
         bus_rdata = $urandom;
         if (bus_wen || bus_ren) begin
            if (dev_en) begin
               if (dev_wait == 0) begin
                  if (dev_fix) bus_rdata = dev_data_fix;
                  bus_ready = 1'b1;
                  rdq.push_back(bus_rdata);
                  dev_wait = (dev_lat >= 0) ? dev_lat : $urandom_range(0, 3);
               end else begin
                  dev_wait--;
               end
            end
         end else begin
            dev_wait = (dev_lat >= 0) ? dev_lat : $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) bus_ready = 1'b1;
         end
      end
   end

   // Monitor: compare every bus cycle and completion against the scoreboard head
   initial begin
      exp_t        e;
      logic [31:0] exp_rd;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_q.delete();
            rdq.delete();
            m_terr = 1'b0;
         end else begin
`ifdef ARB_TIMEOUT_EN
            chk("timeout_err", 64'(timeout_err), 64'(m_terr));
`else
            chk("timeout_err_tied", 64'(timeout_err), 64'(0));
`endif
            if (bus_wen || bus_ren) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_bus_req", 64'(1), 64'(0));
               end else begin
                  e = exp_q[0];
                  chk("bus_addr_wdata", {bus_addr, bus_wdata}, {e.addr, e.wdata});
                  chk("bus_ctl", 64'({bus_wmask, bus_wen, bus_ren, grant_idx, busy}),
                      64'({e.wmask, e.wen, e.ren, 3'(e.host), 1'b1}));
                  if (host_ready != 0) begin
                     void'(exp_q.pop_front());
                     chk("host_ready_route", 64'(host_ready), 64'(1) << e.host);
                     if (e.tmo) begin
                        chk("host_rdata_timeout", 64'(host_rdata), 64'(32'hDEAD_BEEF));
                        m_terr = 1'b1;
                     end else if (rdq.size() > 0) begin
                        exp_rd = rdq.pop_front();
                        chk("host_rdata", 64'(host_rdata), 64'(exp_rd));
                     end else begin
                        chk("ready_without_device", 64'(1), 64'(0));
                     end
                  end else if (bus_ready) begin
                     chk("ready_dropped", 64'(host_ready), 64'(1) << e.host);
                  end
               end
            end else begin
               chk("idle_outputs", 64'({host_ready, busy}), 64'(0));
               chk("rdata_passthru", 64'(host_rdata), 64'(bus_rdata));
            end
         end
      end
   end

   // Issue one batch of simultaneous requests; expected order is rotation from m_last+1
   task automatic run_batch(input logic [NH-1:0] mask, input bit tmo, input bit mutate);
      int         order[$];
      logic [NH-1:0] pend;
      int         cyc;
      int         t_expect;
      int         t_start;
      int         idx;
      exp_t       e;
      @(posedge clk);
      #1;
      for (int h = 0; h < NH; h++) begin
         if (mask[h]) begin
            logic [1:0] kind;
            kind = fx_en ? fx_kind : 2'($urandom_range(1, 3));
            host_addr[h*32 +: 32]  = fx_en ? fx_addr : $urandom;
            host_wdata[h*32 +: 32] = fx_en ? fx_wdata : $urandom;
            host_wmask[h*4 +: 4]   = fx_en ? fx_wmask : 4'($urandom);
            host_wen[h] = kind[1];
            host_ren[h] = kind[0];
         end
      end
      for (int k = 1; k <= NH; k++) begin
         int h;
         h = (m_last + k) % NH;
         if (mask[h]) begin
            e.host  = h;
            e.addr  = host_addr[h*32 +: 32];
            e.wdata = host_wdata[h*32 +: 32];
            e.wmask = host_wmask[h*4 +: 4];
            e.wen   = host_wen[h];
            e.ren   = host_ren[h];
            e.tmo   = tmo;
            exp_q.push_back(e);
            order.push_back(h);
         end
      end
      m_last = order[order.size() - 1];
      pend = mask;
      idx = 0;
      @(negedge clk);
      chk("arb_cycle_idle", 64'({bus_wen, bus_ren, busy}), 64'(0));
      t_expect = 1;
      t_start = 1;
      cyc = 0;
      while (pend != 0 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (cyc == t_expect) begin
            chk("req_latency", 64'(bus_wen | bus_ren), 64'(1));
            t_start = cyc;
         end else if (cyc < t_expect) begin
            chk("gap_no_req", 64'(bus_wen | bus_ren), 64'(0));
         end
         if (host_ready != 0) begin
            for (int h = 0; h < NH; h++) begin
               if (host_ready[h] && pend[h]) begin
                  pend[h] = 1'b0;
                  host_wen[h] = 1'b0;
                  host_ren[h] = 1'b0;
               end
            end
            if (tmo) chk("timeout_latency", 64'(cyc - t_start), 64'(TMO - 1));
            t_expect = cyc + 3;
            idx++;
         end else if (mutate && cyc >= t_expect && idx < order.size()) begin
            host_addr[order[idx]*32 +: 32]  = fx_en ? fx_mut : $urandom;
            host_wdata[order[idx]*32 +: 32] = $urandom;
            host_wmask[order[idx]*4 +: 4]   = 4'($urandom);
         end
      end
      if (pend != 0) begin
         chk("batch_complete", 64'(pend), 64'(0));
         host_wen = '0;
         host_ren = '0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      m_last = NH - 1;
   endtask

   initial begin
      exp_t e;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_fields", {bus_addr, bus_wdata}, 64'(0));
      chk("reset_ctl", 64'({bus_wmask, bus_wen, bus_ren, host_ready, grant_idx, busy, timeout_err}), 64'(0));
      @(posedge clk);
      #1 rst = 1'b1;

      // Lone read from host0, device answers two cycles after bus_ren
      fx_en = 1'b1; fx_addr = 32'h0000_0100; fx_wdata = '0; fx_wmask = '0; fx_kind = 2'b01;
      dev_lat = 2; dev_fix = 1'b1; dev_data_fix = 32'h1234_5678;
      run_batch(3'b001, 1'b0, 1'b0);
      dev_fix = 1'b0;

      // Simultaneous requests after reset: host0 first, then alternation
      do_reset();
      fx_en = 1'b0; dev_lat = -1;
      run_batch(3'b011, 1'b0, 1'b0);
      run_batch(3'b011, 1'b0, 1'b0);
      run_batch(3'b111, 1'b0, 1'b0);

      // Fields locked while host1 changes its address mid-transfer
      fx_en = 1'b1; fx_addr = 32'h10; fx_mut = 32'h20; fx_kind = 2'b01; dev_lat = 3;
      run_batch(3'b010, 1'b0, 1'b1);

      // Write from host1 with partial mask
      fx_addr = 32'h0000_0040; fx_wdata = 32'hA5A5_A5A5; fx_wmask = 4'b0011; fx_kind = 2'b10; dev_lat = 0;
      run_batch(3'b010, 1'b0, 1'b0);

      // Randomized traffic
      fx_en = 1'b0; dev_lat = -1;
      for (int i = 0; i < 40; i++) begin
         run_batch(3'($urandom_range(1, 7)), 1'b0, 1'($urandom_range(0, 1)));
      end

`ifdef ARB_TIMEOUT_EN
      // Ready on the expiry cycle completes normally; a silent device times out
      dev_lat = TMO - 1;
      run_batch(3'b100, 1'b0, 1'b0);
      dev_en = 1'b0;
      run_batch(3'b001, 1'b1, 1'b0);
      dev_en = 1'b1; dev_lat = -1;
      run_batch(3'b111, 1'b0, 1'b0);
`endif

      // Reset in the middle of a stalled host1 write
      dev_en = 1'b0;
      @(posedge clk);
      #1;
      host_addr[32 +: 32] = 32'h55; host_wdata[32 +: 32] = 32'h66; host_wmask[7:4] = 4'hF;
      host_wen[1] = 1'b1;
      e.host = 1; e.addr = 32'h55; e.wdata = 32'h66; e.wmask = 4'hF; e.wen = 1'b1; e.ren = 1'b0; e.tmo = 1'b0;
      exp_q.push_back(e);
      repeat (3) @(negedge clk);
      chk("rst_pre_xfer", 64'(bus_wen), 64'(1));
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      host_wen[1] = 1'b0;
      m_last = NH - 1;
      dev_en = 1'b1;
      @(negedge clk);
      chk("rst_mid_xfer", 64'({bus_wen, bus_ren, busy, host_ready, grant_idx, timeout_err}), 64'(0));
      run_batch(3'b111, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
